// File: rtl/vga_pkg.sv
// Shared VGA definitions for the 800x600 @ 40 MHz pixel pipeline stages.
// Timing constants, colour type and the packed timing bus carried between stages.
package vga_pkg;

  localparam int HOR_VISIBLE    = 800;
  localparam int HOR_SYNC_START = 840;
  localparam int HOR_SYNC_END   = 968;
  localparam int HOR_TOTAL      = 1056;
  localparam int VER_VISIBLE    = 600;
  localparam int VER_SYNC_START = 601;
  localparam int VER_SYNC_END   = 605;
  localparam int VER_TOTAL      = 628;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);

  typedef enum logic {
    WAIT_POS = 1'b0,
    DRAW     = 1'b1
  } pos_state_t;

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth register delay line, cleared by asynchronous active-low reset.
module signal_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays a fixed-size solid rectangle on the pixel stream; the position is
// sampled once per frame at the start of vertical blanking. Latency 2 cycles.
//
// state    | meaning
// WAIT_POS | no position latched yet, stream passes through
// DRAW     | rectangle drawn at x_q/y_q, re-latched at every frame start
module draw_rect
  import vga_pkg::*;
#(
  parameter int   RECT_W     = 64,
  parameter int   RECT_H     = 48,
  parameter rgb_t RECT_COLOR = 12'hf_8_0
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  pos_state_t  state;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic        vblnk_prev;
  logic        armed;
  logic        frame_start;

  // armed suppresses a false frame start when reset releases inside blanking
  assign frame_start = vblnk_in & ~vblnk_prev & armed;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_POS;
      x_q        <= '0;
      y_q        <= '0;
      vblnk_prev <= 1'b0;
      armed      <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      armed      <= 1'b1;
      case (state)
        WAIT_POS: begin
          if (frame_start) begin
            x_q   <= xpos;
            y_q   <= ypos;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (frame_start) begin
            x_q <= xpos;
            y_q <= ypos;
          end
        end
        default: state <= WAIT_POS;
      endcase
    end
  end

  logic [12:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;
  logic        hit;

  // 13-bit compares so that position + size can never wrap
  assign h_ext = {2'b00, hcount_in};
  assign v_ext = {2'b00, vcount_in};
  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};
  assign x_end = x_ext + 13'(RECT_W);
  assign y_end = y_ext + 13'(RECT_H);
  assign hit   = (state == DRAW) && (h_ext >= x_ext) && (h_ext < x_end) &&
                 (v_ext >= y_ext) && (v_ext < y_end);

  logic        hit_q;
  logic        blank_q;
  logic [11:0] rgb_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      blank_q <= 1'b0;
      rgb_q   <= '0;
      rgb_out <= '0;
    end else begin
      hit_q   <= hit;
      blank_q <= hblnk_in | vblnk_in;
      rgb_q   <= rgb_in;
      rgb_out <= blank_q ? 12'h000 : (hit_q ? RECT_COLOR : rgb_q);
    end
  end

  vga_bus_t               bus_in;
  vga_bus_t               bus_out;
  logic [VGA_BUS_W-1:0]   bus_out_raw;

  assign bus_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  signal_delay #(
    .WIDTH (VGA_BUS_W),
    .DEPTH (2)
  ) u_bus_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (bus_in),
    .dout  (bus_out_raw)
  );

  assign bus_out    = vga_bus_t'(bus_out_raw);
  assign hcount_out = bus_out.hcount;
  assign vcount_out = bus_out.vcount;
  assign hsync_out  = bus_out.hsync;
  assign vsync_out  = bus_out.vsync;
  assign hblnk_out  = bus_out.hblnk;
  assign vblnk_out  = bus_out.vblnk;

endmodule

// File: tb/tb_draw_rect.sv
// Scoreboard bench for draw_rect: the driver pushes expected outputs per pixel,
// a negedge monitor pops and compares them two cycles later.
`timescale 1ns/1ps
module tb_draw_rect;
  import vga_pkg::*;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_rect dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    vga_bus_t    bus;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vga_bus_t mk_bus(int h, int v);
    vga_bus_t b;
    b.hcount = 11'(h);
    b.vcount = 11'(v);
    b.hsync  = (h >= HOR_SYNC_START) && (h < HOR_SYNC_END);
    b.vsync  = (v >= VER_SYNC_START) && (v < VER_SYNC_END);
    b.hblnk  = (h >= HOR_VISIBLE);
    b.vblnk  = (v >= VER_VISIBLE);
    return b;
  endfunction

  // expected colour for a 64x48 rectangle at (x,y)
  function automatic logic [11:0] exp_px(int h, int v, int x, int y, bit drawn, logic [11:0] bg);
    if (h >= 800 || v >= 600) return 12'h000;
    if (drawn && h >= x && h < x + 64 && v >= y && v < y + 48) return 12'hf80;
    return bg;
  endfunction

  task automatic drive_now(int h, int v, logic [11:0] bg, logic [11:0] exp_rgb);
    exp_t e;
    vga_bus_t b;
    b = mk_bus(h, v);
    hcount_in = b.hcount; vcount_in = b.vcount;
    hsync_in = b.hsync; vsync_in = b.vsync; hblnk_in = b.hblnk; vblnk_in = b.vblnk;
    rgb_in = bg;
    e.bus = b;
    e.rgb = exp_rgb;
    q.push_back(e);
  endtask

  task automatic pix(int h, int v, logic [11:0] bg, logic [11:0] exp_rgb);
    @(posedge pclk); #1;
    drive_now(h, v, bg, exp_rgb);
  endtask

  // end of a visible frame followed by the first blanking line: frame start at (0,600)
  task automatic frame_start(int x, int y);
    xpos = 12'(x); ypos = 12'(y);
    pix(1055, 599, 12'h555, 12'h000);
    pix(0, 600, 12'h555, 12'h000);
    pix(1, 600, 12'h555, 12'h000);
  endtask

  task automatic rand_inputs();
    hcount_in = 11'($urandom); vcount_in = 11'($urandom);
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
    rgb_in = 12'($urandom);
  endtask

  task automatic reset_for(int n);
    @(posedge pclk); #1;
    rst_n = 1'b0;
    q.delete();
    rand_inputs();
    for (int i = 1; i < n; i++) begin
      @(posedge pclk); #1;
      rand_inputs();
    end
  endtask

  task automatic release_with(int h, int v, logic [11:0] bg, logic [11:0] exp_rgb);
    @(posedge pclk); #1;
    rst_n = 1'b1;
    drive_now(h, v, bg, exp_rgb);
  endtask

  always @(negedge pclk) begin
    vga_bus_t got;
    exp_t     e;
    got = '{hcount: hcount_out, vcount: vcount_out, hsync: hsync_out,
            vsync: vsync_out, hblnk: hblnk_out, vblnk: vblnk_out};
    if (!rst_n) begin
      n_checks++;
      if (got != '0 || rgb_out != 12'h000) begin
        n_fail++;
        $display("FAIL reset_zero: bus=%h rgb=%h, required all zero", got, rgb_out);
      end
    end else if (q.size() >= 3) begin
      e = q.pop_front();
      n_checks++;
      if (got != e.bus) begin
        n_fail++;
        $display("FAIL timing_bus at (%0d,%0d): got %h, required %h",
                 e.bus.hcount, e.bus.vcount, got, e.bus);
      end
      n_checks++;
      if (rgb_out != e.rgb) begin
        n_fail++;
        $display("FAIL rgb at (%0d,%0d): got %h, required %h",
                 e.bus.hcount, e.bus.vcount, rgb_out, e.rgb);
      end
    end
  end

  initial begin
    xpos = 12'd100; ypos = 12'd50;
    // reset with toggling inputs, then pass-through before any frame start
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      rand_inputs();
    end
    release_with(0, 60, 12'h888, 12'h888);
    for (int h = 1; h < 140; h += 7) pix(h, 60, 12'h888, 12'h888);
    pix(900, 60, 12'h888, 12'h000);

    // pass-through with an off-screen position
    frame_start(900, 0);
    for (int h = 0; h < 1056; h += 3) pix(h, 0, 12'h888, (h < 800) ? 12'h888 : 12'h000);
    for (int v = 590; v < 628; v++) pix(920, v, 12'h888, 12'h000);
    for (int v = 590; v < 628; v++) pix(5, v, 12'h888, (v < 600) ? 12'h888 : 12'h000);

    // placement corners and neighbours
    frame_start(100, 50);
    pix(100, 50, 12'h123, 12'hf80);
    pix(163, 50, 12'h123, 12'hf80);
    pix(100, 97, 12'h123, 12'hf80);
    pix(163, 97, 12'h123, 12'hf80);
    pix(99, 50, 12'h123, 12'h123);
    pix(164, 50, 12'h123, 12'h123);
    pix(100, 49, 12'h123, 12'h123);
    pix(100, 98, 12'h123, 12'h123);
    for (int h = 90; h < 175; h += 2) pix(h, 60, 12'h123, exp_px(h, 60, 100, 50, 1, 12'h123));

    // position change mid-frame only takes effect after the next frame start
    xpos = 12'd300;
    pix(0, 200, 12'h123, 12'h123);
    pix(100, 60, 12'h123, 12'hf80);
    pix(300, 60, 12'h123, 12'h123);
    frame_start(300, 50);
    pix(100, 60, 12'h123, 12'h123);
    pix(299, 60, 12'h123, 12'h123);
    pix(300, 60, 12'h123, 12'hf80);
    pix(363, 60, 12'h123, 12'hf80);
    pix(364, 60, 12'h123, 12'h123);

    // clipping at the right and bottom edges
    frame_start(780, 580);
    for (int h = 770; h < 850; h++) pix(h, 590, 12'h0a0, exp_px(h, 590, 780, 580, 1, 12'h0a0));
    pix(799, 599, 12'h0a0, 12'hf80);
    pix(820, 585, 12'h0a0, 12'h000);
    for (int v = 575; v < 628; v++) pix(790, v, 12'h0a0, exp_px(790, v, 780, 580, 1, 12'h0a0));

    // reset mid-frame at vcount 300
    frame_start(100, 50);
    pix(110, 60, 12'h123, 12'hf80);
    pix(0, 300, 12'h123, 12'h123);
    reset_for(5);
    release_with(1, 300, 12'h123, 12'h123);
    pix(110, 60, 12'h123, 12'h123);
    pix(163, 97, 12'h123, 12'h123);
    frame_start(100, 50);
    pix(110, 60, 12'h123, 12'hf80);
    pix(164, 60, 12'h123, 12'h123);

    // reset released inside vertical blanking: no frame start until the next one
    reset_for(4);
    release_with(0, 610, 12'h123, 12'h000);
    pix(1, 610, 12'h123, 12'h000);
    pix(2, 611, 12'h123, 12'h000);
    pix(110, 60, 12'h123, 12'h123);
    pix(100, 50, 12'h123, 12'h123);
    frame_start(100, 50);
    pix(110, 60, 12'h123, 12'hf80);
    pix(100, 50, 12'h123, 12'hf80);

    for (int i = 0; i < 3; i++) pix(400, 400, 12'h321, 12'h321);
    repeat (3) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_rect.md
# draw_rect

Pixel-pipeline stage directly downstream of `vga_timing` (800x600, 40 MHz, 1056x628 totals). Consumes the timing bus plus a background colour from the previous draw stage and overlays a solid, fixed-size rectangle whose top-left position is sampled once per frame. Re-emits the complete timing bus, delayed to match the colour, so further draw stages or the VGA output register can be chained after it.

## Interface
- `RECT_W`, 64: rectangle width in pixels, 1..800.
- `RECT_H`, 48: rectangle height in pixels, 1..600.
- `RECT_COLOR`, 12'hf_8_0: rectangle colour, {r,g,b} 4 bits each.
- `pclk` input 1: pixel clock, 40 MHz; all state on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low (fixed); release is synchronous to `pclk` upstream.
- `hcount_in`, `vcount_in` input 11 each: pixel coordinates from `vga_timing`.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` input 1 each: active-high sync and blank flags.
- `rgb_in` input 12: background colour for the current pixel.
- `xpos`, `ypos` input 12 each: requested top-left corner; sampled only at frame start.
- `hcount_out`, `vcount_out` output 11 each: `*_in` delayed 2 cycles.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` output 1 each: `*_in` delayed 2 cycles.
- `rgb_out` output 12: composited colour, aligned with `*_out`.

## Operation
- Frame-start detect: registered `vblnk_prev`; `frame_start = vblnk_in & ~vblnk_prev`, which fires on the first cycle of vertical blanking (vcount 600, hcount 0).
- Position FSM, 2 states:
  - `WAIT_POS` (reset state): rectangle not drawn. On `frame_start`, latch `xpos`/`ypos` into `x_q`/`y_q` and go to `DRAW`.
  - `DRAW`: rectangle drawn at `x_q`/`y_q`. On each `frame_start`, re-latch. No other exit except reset.
- `xpos`/`ypos` changes outside `frame_start` have no effect until the next frame. No tearing.
- Stage 1, registered:
  - `hit = (state==DRAW) & hcount_in>=x_q & hcount_in<x_q+RECT_W & vcount_in>=y_q & vcount_in<y_q+RECT_H`.
  - `blank = hblnk_in | vblnk_in`.
  - Register `rgb_in` and the full timing bus.
- Stage 2, registered:
  - `rgb_out = blank ? 12'h000 : (hit ? RECT_COLOR : rgb_in)`.
  - Timing bus advances one more stage.
- Arithmetic:
  - Compare in 13 bits unsigned: zero-extend counts and positions.
  - Compute `x_q+RECT_W` and `y_q+RECT_H` in 13 bits so the sum never wraps.
- Clipping:
  - Any rectangle part at hcount>=800 or vcount>=600 is forced black by the blank term.
  - Any position >=1056/628 yields no hit at all.

## Timing
- Latency 2 cycles, identical for every output: a pixel entering on cycle n leaves on cycle n+2.
- Throughput 1 pixel/cycle. No stalls, no handshake.
- Position takes effect for the frame whose vcount 0 follows the latching `frame_start`.
- Reset state (async, while `rst_n`=0):
  - All outputs 0 and all pipeline registers 0.
  - `x_q`/`y_q` = 0, `vblnk_prev` = 0.
  - FSM in `WAIT_POS`.
- Reset mid-frame:
  - Outputs drop to 0 immediately.
  - After release, output is pass-through (background/black) until the first `frame_start`.
  - If `vblnk_in` is already 1 at release, no `frame_start` occurs until the following frame's blanking begins.
- `frame_start` coinciding with a hit pixel is impossible (hit requires vcount<600). Latching and drawing never conflict.

## Structure
- Shared package `vga_pkg` holds:
  - Timing constants: `HOR_VISIBLE`=800, `HOR_SYNC_START`=840, `HOR_SYNC_END`=968, `HOR_TOTAL`=1056, `VER_VISIBLE`=600, `VER_SYNC_START`=601, `VER_SYNC_END`=605, `VER_TOTAL`=628.
  - `typedef logic [11:0] rgb_t`.
  - A `vga_bus_t` struct: hcount, vcount, hsync, vsync, hblnk, vblnk.
- One sub-module, `signal_delay` (parameters `WIDTH`, `DEPTH`; async active-low reset to 0), carries the packed timing bus through both stages.

## Test plan
- Reset: hold `rst_n`=0 with random inputs toggling -> every output 0; release -> `hcount_out` equals `hcount_in` from 2 cycles earlier.
- Pass-through: `xpos`=900, `ypos`=0, `rgb_in`=12'h888 -> `rgb_out`=12'h888 at all visible pixels, 12'h000 in blanking; syncs match `vga_timing` delayed 2.
- Placement: `xpos`=100, `ypos`=50, defaults, after one `frame_start`:
  - Pixels (100,50), (163,50), (100,97), (163,97) show 12'hf80.
  - Pixels (99,50), (164,50), (100,49), (100,98) show `rgb_in`.
- Frame-synchronous update: change `xpos` to 300 at vcount 200 -> current frame still drawn at x=100; next frame drawn at x=300..363.
- Clipping: `xpos`=780, `ypos`=580 -> hcount 780..799 and vcount 580..599 show 12'hf80; hcount 800..843 and vcount 600..627 show 12'h000.
- Reset mid-frame: assert `rst_n` at vcount 300 for 5 cycles -> no 12'hf80 until after the next vcount-600 `frame_start`; the following frame is drawn correctly.
